// File: rtl/edge_detector_pkg.sv
// edge_detector_pkg: mode encodings, parameter limits and qualified-event selection
package edge_detector_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_ANY  = 2'b10,
        MODE_NONE = 2'b11
    } mode_e;

    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 32;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int DEBOUNCE_MAX    = 65535;

    // Picks the pulse that counts as an event for the sticky flags; "none" masks everything
    function automatic logic select_event(input logic [1:0] mode, input logic rise,
                                          input logic fall, input logic any);
        return (mode == MODE_NONE) ? 1'b0 :
               (mode == MODE_ANY)  ? any  :
               (mode == MODE_FALL) ? fall : rise;
    endfunction

endpackage

// File: rtl/edge_channel.sv
// edge_channel: one input lane - synchroniser, optional debounce, edge pulses, pending/overrun flags
module edge_channel
    import edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iExternalInput,
    input  logic [1:0] iMode,
    input  logic       iClear,
    output logic       oFlancosP,
    output logic       oFlancosN,
    output logic       oFlancosX,
    output logic       oLevel,
    output logic       oPending,
    output logic       oOverrun,
    output logic       oPendingNext
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   stable;
    logic                   prev_q;
    logic                   p_q, n_q, x_q;
    logic                   p_d, n_d, x_d;
    logic                   q;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) sync_q <= '0;
        else           sync_q <= {sync_q[SYNC_STAGES-2:0], iExternalInput};
    end

    assign s = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
        assign stable = s;
    end else begin : g_debounce
        localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
        logic [CW-1:0] cnt_q, cnt_d;
        logic          stable_q, stable_d;
        // Accept a new level only after it has differed from the stable one for the full window
        always_comb begin
            stable_d = (s != stable_q && cnt_q == CNT_LAST) ? s : stable_q;
            cnt_d    = (s == stable_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        // Debounce state
        always_ff @(posedge iClk or negedge iReset_n) begin
            if (!iReset_n) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end
        assign stable = stable_q;
    end

    // Edge pulses and sticky flags; an event beats a clear so it is never lost
    always_comb begin
        p_d       = stable & ~prev_q;
        n_d       = ~stable & prev_q;
        x_d       = stable ^ prev_q;
        q         = select_event(iMode, p_d, n_d, x_d);
        pending_d = q | (pending_q & ~iClear);
        overrun_d = q ? (overrun_q | pending_q) : (overrun_q & ~iClear);
    end

    // Register pulses, previous level and the flags
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            prev_q    <= 1'b0;
            p_q       <= 1'b0;
            n_q       <= 1'b0;
            x_q       <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            prev_q    <= stable;
            p_q       <= p_d;
            n_q       <= n_d;
            x_q       <= x_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign oFlancosP    = p_q;
    assign oFlancosN    = n_q;
    assign oFlancosX    = x_q;
    assign oLevel       = stable;
    assign oPending     = pending_q;
    assign oOverrun     = overrun_q;
    assign oPendingNext = pending_d;

endmodule

// File: rtl/edge_detector_bank.sv
// edge_detector_bank: CHANNELS independent edge detectors with sticky flags and a combined interrupt
module edge_detector_bank
    import edge_detector_pkg::*;
#(
    parameter int CHANNELS        = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic                iClk,
    input  logic                iReset_n,
    input  logic [CHANNELS-1:0] iExternalInput,
    input  logic [1:0]          iMode,
    input  logic [CHANNELS-1:0] iClear,
    output logic [CHANNELS-1:0] oFlancosP,
    output logic [CHANNELS-1:0] oFlancosN,
    output logic [CHANNELS-1:0] oFlancosX,
    output logic [CHANNELS-1:0] oLevel,
    output logic [CHANNELS-1:0] oPending,
    output logic [CHANNELS-1:0] oOverrun,
    output logic                oIrq
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
        SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
        DEBOUNCE_CYCLES < 0 || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_params
        $error("edge_detector_bank: parameter out of range");
    end

    logic [CHANNELS-1:0] pending_d;
    logic                irq_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .iClk          (iClk),
            .iReset_n      (iReset_n),
            .iExternalInput(iExternalInput[c]),
            .iMode         (iMode),
            .iClear        (iClear[c]),
            .oFlancosP     (oFlancosP[c]),
            .oFlancosN     (oFlancosN[c]),
            .oFlancosX     (oFlancosX[c]),
            .oLevel        (oLevel[c]),
            .oPending      (oPending[c]),
            .oOverrun      (oOverrun[c]),
            .oPendingNext  (pending_d[c])
        );
    end

    // Interrupt follows next-state pending so it rises together with the flag
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) irq_q <= 1'b0;
        else           irq_q <= |pending_d;
    end

    assign oIrq = irq_q;

endmodule

// File: tb/tb_edge_detector_bank.sv
// tb_edge_detector_bank: directed and randomized checks of two bank configurations against a history-based model
module tb_edge_detector_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din, clr;
    logic [1:0]  mode;
    logic [31:0] a_p, a_n, a_x, a_l, a_pd, a_ov;
    logic [31:0] b_p, b_n, b_x, b_l, b_pd, b_ov;
    logic        a_irq, b_irq;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    edge_detector_bank #(.CHANNELS(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut_a (
        .iClk(clk), .iReset_n(rst_n), .iExternalInput(din), .iMode(mode), .iClear(clr),
        .oFlancosP(a_p), .oFlancosN(a_n), .oFlancosX(a_x), .oLevel(a_l),
        .oPending(a_pd), .oOverrun(a_ov), .oIrq(a_irq));

    edge_detector_bank #(.CHANNELS(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_b (
        .iClk(clk), .iReset_n(rst_n), .iExternalInput(din), .iMode(mode), .iClear(clr),
        .oFlancosP(b_p), .oFlancosN(b_n), .oFlancosX(b_x), .oLevel(b_l),
        .oPending(b_pd), .oOverrun(b_ov), .oIrq(b_irq));

    // Reference model: input history per edge; index 0 is the newest sample
    logic [31:0] samp[$];
    logic [31:0] e_st[2], e_pv[2], e_p[2], e_n[2], e_x[2], e_pd[2], e_ov[2];
    logic        e_irq[2];
    int          deb[2] = '{0, 4};

    task automatic model_reset();
        samp = {};
        repeat (8) samp.push_front('0);
        for (int u = 0; u < 2; u++) begin
            e_st[u] = '0; e_pv[u] = '0; e_p[u] = '0; e_n[u] = '0; e_x[u] = '0;
            e_pd[u] = '0; e_ov[u] = '0; e_irq[u] = 1'b0;
        end
    endtask

    // A level is accepted once the synchronised input has shown it for deb consecutive edges
    task automatic model_step();
        logic [31:0] nst, q;
        logic        same;
        samp.push_front(din);
        if (samp.size() > 8) void'(samp.pop_back());
        for (int u = 0; u < 2; u++) begin
            nst = e_st[u];
            if (deb[u] == 0) nst = samp[1];
            else for (int c = 0; c < 32; c++) begin
                same = 1'b1;
                for (int k = 2; k <= deb[u] + 1; k++) if (samp[k][c] !== samp[2][c]) same = 1'b0;
                if (same && samp[2][c] !== e_st[u][c]) nst[c] = samp[2][c];
            end
            e_p[u] = e_st[u] & ~e_pv[u];
            e_n[u] = ~e_st[u] & e_pv[u];
            e_x[u] = e_st[u] ^ e_pv[u];
            q = (mode == 2'b00) ? e_p[u] : (mode == 2'b01) ? e_n[u] : (mode == 2'b10) ? e_x[u] : '0;
            e_ov[u] = (q & (e_ov[u] | e_pd[u])) | (~q & e_ov[u] & ~clr);
            e_pd[u] = q | (e_pd[u] & ~clr);
            e_irq[u] = |e_pd[u];
            e_pv[u] = e_st[u];
            e_st[u] = nst;
        end
    endtask

    function automatic logic [192:0] obs_a();
        return {a_p, a_n, a_x, a_l, a_pd, a_ov, a_irq};
    endfunction

    function automatic logic [192:0] obs_b();
        return {b_p, b_n, b_x, b_l, b_pd, b_ov, b_irq};
    endfunction

    function automatic logic [192:0] exp_of(input int u);
        return {e_p[u], e_n[u], e_x[u], e_st[u], e_pd[u], e_ov[u], e_irq[u]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (obs_a() !== '0) begin errors++; $display("FAIL reset_a got %0h want 0", obs_a()); end
        checks++; if (obs_b() !== '0) begin errors++; $display("FAIL reset_b got %0h want 0", obs_b()); end
        repeat (3) tick();
        checks++; if (obs_a() !== exp_of(0)) begin errors++; $display("FAIL idle_a got %0h want %0h", obs_a(), exp_of(0)); end
        checks++; if (obs_b() !== exp_of(1)) begin errors++; $display("FAIL idle_b got %0h want %0h", obs_b(), exp_of(1)); end
    endtask

    task automatic test_latency();
        mode = 2'b00;
        din[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (a_l[0] !== (i >= 1)) begin errors++; $display("FAIL lat_level i=%0d got %b want %b", i, a_l[0], i >= 1); end
            checks++; if (a_p[0] !== (i == 2)) begin errors++; $display("FAIL lat_p i=%0d got %b want %b", i, a_p[0], i == 2); end
            checks++; if (a_x[0] !== (i == 2)) begin errors++; $display("FAIL lat_x i=%0d got %b want %b", i, a_x[0], i == 2); end
            checks++; if (a_n[0] !== 1'b0) begin errors++; $display("FAIL lat_n i=%0d got %b want 0", i, a_n[0]); end
            checks++; if (a_pd[0] !== (i >= 2)) begin errors++; $display("FAIL lat_pend i=%0d got %b want %b", i, a_pd[0], i >= 2); end
            checks++; if (a_irq !== (i >= 2)) begin errors++; $display("FAIL lat_irq i=%0d got %b want %b", i, a_irq, i >= 2); end
        end
    endtask

    task automatic test_debounce();
        logic seen = 1'b0;
        repeat (2) begin
            din[1] = 1'b1;
            repeat (3) begin tick(); seen |= b_p[1] | b_l[1]; end
            din[1] = 1'b0;
            repeat (8) begin tick(); seen |= b_p[1] | b_l[1]; end
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch got %b want 0", seen); end
        checks++; if (b_pd[1] !== 1'b0) begin errors++; $display("FAIL glitch_pend got %b want 0", b_pd[1]); end
        din[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (b_p[1] !== (i == 6)) begin errors++; $display("FAIL deb_p i=%0d got %b want %b", i, b_p[1], i == 6); end
            checks++; if (b_l[1] !== (i >= 5 && i <= 10)) begin errors++; $display("FAIL deb_level i=%0d got %b want %b", i, b_l[1], i >= 5 && i <= 10); end
            if (i == 5) din[1] = 1'b0;
        end
    endtask

    task automatic test_mode();
        logic sp = 1'b0, sn = 1'b0;
        clr = '1; tick(); clr = '0;
        mode = 2'b01;
        din[2] = 1'b1;
        repeat (4) begin tick(); sp |= a_p[2]; end
        checks++; if (sp !== 1'b1) begin errors++; $display("FAIL fall_mode_rise_pulse got %b want 1", sp); end
        checks++; if (a_pd[2] !== 1'b0) begin errors++; $display("FAIL fall_mode_rise got %b want 0", a_pd[2]); end
        din[2] = 1'b0;
        repeat (4) tick();
        checks++; if (a_pd[2] !== 1'b1) begin errors++; $display("FAIL fall_mode_fall got %b want 1", a_pd[2]); end
        clr[2] = 1'b1; tick(); clr = '0;
        mode = 2'b11;
        sp = 1'b0;
        din[2] = 1'b1;
        repeat (4) begin tick(); sp |= a_p[2] & a_x[2]; end
        din[2] = 1'b0;
        repeat (4) begin tick(); sn |= a_n[2] & a_x[2]; end
        checks++; if ({sp, sn} !== 2'b11) begin errors++; $display("FAIL none_mode_pulses got %b want 11", {sp, sn}); end
        checks++; if (a_pd[2] !== 1'b0) begin errors++; $display("FAIL none_mode_pend got %b want 0", a_pd[2]); end
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL none_mode_irq got %b want 0", a_irq); end
    endtask

    task automatic test_overrun();
        mode = 2'b00;
        clr = '1; tick(); clr = '0;
        din[3] = 1'b1; repeat (4) tick();
        din[3] = 1'b0; repeat (4) tick();
        din[3] = 1'b1; repeat (4) tick();
        checks++; if ({a_pd[3], a_ov[3]} !== 2'b11) begin errors++; $display("FAIL overrun got %b want 11", {a_pd[3], a_ov[3]}); end
        clr[3] = 1'b1; tick(); clr = '0;
        checks++; if ({a_pd[3], a_ov[3]} !== 2'b00) begin errors++; $display("FAIL clear got %b want 00", {a_pd[3], a_ov[3]}); end
        din[3] = 1'b0; repeat (4) tick();
        din[3] = 1'b1; tick(); tick();
        clr[3] = 1'b1; tick(); clr = '0;
        checks++; if ({a_p[3], a_pd[3], a_ov[3]} !== 3'b110) begin errors++; $display("FAIL collide got %b want 110", {a_p[3], a_pd[3], a_ov[3]}); end
        din[3] = 1'b0; repeat (4) tick();
        din[3] = 1'b1; tick(); tick();
        clr[3] = 1'b1; tick(); clr = '0;
        checks++; if ({a_pd[3], a_ov[3]} !== 2'b11) begin errors++; $display("FAIL collide_set got %b want 11", {a_pd[3], a_ov[3]}); end
    endtask

    task automatic test_back_to_back();
        mode = 2'b10;
        din[4] = 1'b1; tick(); din[4] = 1'b0;
        for (int i = 1; i < 5; i++) begin
            tick();
            checks++; if ({a_p[4], a_n[4], a_x[4]} !== {i == 2, i == 3, i == 2 || i == 3}) begin
                errors++; $display("FAIL b2b i=%0d got %b want %b", i, {a_p[4], a_n[4], a_x[4]}, {i == 2, i == 3, i == 2 || i == 3});
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 2'b00;
        din[0] = 1'b1;
        din[1] = 1'b1;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (obs_a() !== '0) begin errors++; $display("FAIL async_a got %0h want 0", obs_a()); end
        checks++; if (obs_b() !== '0) begin errors++; $display("FAIL async_b got %0h want 0", obs_b()); end
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (a_p[0] !== (i == 2)) begin errors++; $display("FAIL rel_a i=%0d got %b want %b", i, a_p[0], i == 2); end
            checks++; if (b_p[0] !== (i == 6)) begin errors++; $display("FAIL rel_b i=%0d got %b want %b", i, b_p[0], i == 6); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) mode = 2'($urandom_range(0, 3));
            din ^= $urandom() & $urandom() & $urandom();
            clr = ($urandom_range(0, 3) == 0) ? $urandom() : '0;
            tick();
            checks++; if (obs_a() !== exp_of(0)) begin errors++; $display("FAIL rand_a i=%0d got %0h want %0h", i, obs_a(), exp_of(0)); end
            checks++; if (obs_b() !== exp_of(1)) begin errors++; $display("FAIL rand_b i=%0d got %0h want %0h", i, obs_b(), exp_of(1)); end
        end
        clr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        din   = '0;
        clr   = '0;
        mode  = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_latency();
        test_debounce();
        test_mode();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_detector_bank.md
# edge_detector_bank

Parametrised, multi-channel successor to the single-input edge detector. It provides per-channel input synchronisation, optional debounce filtering, and one-cycle rising, falling and any-edge pulses. It also keeps a per-channel sticky event flag with a write-1-to-clear interface, an overrun flag and a combined interrupt line. It sits between raw board inputs (buttons, switches, external strobes) and the counter and control logic that consumes edge events.

## Interface
Parameters:
- CHANNELS, default 8: number of independent input channels, 1..32.
- SYNC_STAGES, default 2: synchroniser flop depth, 2..4.
- DEBOUNCE_CYCLES, default 0: consecutive stable cycles required before a level change is accepted; 0 bypasses the filter; maximum 65535.

Ports:
- iClk, in, 1: single clock; every flop is on the rising edge.
- iReset_n, in, 1: reset, asynchronous and active-low.
- iExternalInput, in, CHANNELS: raw asynchronous inputs.
- iMode, in, 2: global event-qualify mode. 00 = rising, 01 = falling, 10 = any, 11 = none.
- iClear, in, CHANNELS: write-1-to-clear strobe for oPending and oOverrun, per channel.
- oFlancosP, out, CHANNELS: one-cycle rising-edge pulses.
- oFlancosN, out, CHANNELS: one-cycle falling-edge pulses.
- oFlancosX, out, CHANNELS: one-cycle any-edge pulses.
- oLevel, out, CHANNELS: filtered (stable) level.
- oPending, out, CHANNELS: sticky qualified-event flags.
- oOverrun, out, CHANNELS: sticky flag, set on a qualified event while pending is already set.
- oIrq, out, 1: OR-reduction of oPending (registered).

## Operation
- Per channel, the pipeline is: synchroniser, then debounce, then stable level, then edge detect, then event logic.
- Synchroniser: a SYNC_STAGES-deep shift chain; its last stage is the synchronised input `s`.
- Debounce (DEBOUNCE_CYCLES > 0):
  - Counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1).
  - When `s` equals stable: `cnt` is set to 0.
  - Otherwise, if `cnt` equals DEBOUNCE_CYCLES-1: stable takes `s` and `cnt` is set to 0.
  - Otherwise `cnt` increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the count and never reaches stable.
- Debounce bypassed (DEBOUNCE_CYCLES = 0): stable equals `s`.
- Edge detect: register `prev` follows stable each cycle.
  - oFlancosP is registered from stable & ~prev.
  - oFlancosN is registered from ~stable & prev.
  - oFlancosX is registered from stable ^ prev.
- Qualified event `q`: the P, N or X pulse selected by iMode; iMode 11 gives `q` = 0. Mode is sampled each cycle, and a mode change affects only events from that cycle on.
- Pending priority, per channel:
  - If `q` is set, pending is set to 1, and overrun is set to 1 if pending was already 1.
  - Else if iClear is set, pending and overrun are set to 0.
  - A simultaneous `q` and iClear keeps pending set, so the event is never lost. Overrun is evaluated against the pre-clear pending value.
- oIrq is registered from the OR of next-state pending.
- Reset values: every flop is 0, so every output reads 0 and stable/prev start at 0.
  - An input held high through reset produces one rising edge at full latency after release. This is intended and signals "input already active".
- Reset asserted mid-debounce or mid-pulse clears everything immediately; no pulse completes.

## Timing
- An input change captured by the first sync flop at edge k gives `s` at edge k+SYNC_STAGES-1.
- The stable change lands at edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES.
- Edge pulse and pending go high after edge k+SYNC_STAGES+DEBOUNCE_CYCLES, for exactly one cycle; oIrq goes high in the same cycle.
- oLevel leads the pulses by one cycle.
- iClear is applied at the next edge, so oPending drops one cycle after iClear is sampled high.
- Back-to-back opposite edges on stable produce consecutive single-cycle N and P pulses; they do not merge.
- Channels are fully independent, with no arbitration.

## Structure
- Package `edge_detector_pkg` holds:
  - the mode constants MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_ANY=2'b10, MODE_NONE=2'b11;
  - the parameter range limits.
- Sub-module `edge_channel` covers one channel: sync, debounce, edge detect, pending and overrun.
- The top level generates CHANNELS instances and the oIrq reduction.
- Parameter range checks run at elaboration as an initial assertion.

## Test plan
- **Rising-edge latency.** With SYNC=2, DEB=0, mode 00, drive ch0 0 to 1 at edge 10. Required response: oFlancosP[0] high only for the cycle after edge 12; oPending[0] and oIrq go to 1 at the same time; N and X behave to match.
- **Debounce.** With DEB=4, apply 3-cycle high glitches on ch1, which must give no pulse and oLevel=0. Then a 6-cycle high must give one P pulse at edge k+2+4 and oLevel=1.
- **Mode sweep.** Toggle ch2 0→1→0 in mode 01 (falling), which must set pending only on the fall. In mode 11, neither edge may set pending, while the P/N/X pulses still appear.
- **Clear, overrun and collision.**
  - Two qualified events without a clear: oOverrun[3]=1.
  - iClear[3] alone: pending and overrun both go to 0.
  - iClear coinciding with `q`: pending stays 1 and overrun stays 0.
- **Async reset.** Assert iReset_n low mid-debounce with no clock edge. All outputs must go to 0 immediately. Release it with an input held high: one P pulse must follow at full latency.
- **Multi-channel.** With CHANNELS=32, toggle random patterns on all channels. A scoreboard must match per-channel pulses, oLevel and oIrq with no cross-channel interference.
